lcd_bus_reader: RTL

LCD_BUS_READER -- requirements
Module: lcd_bus_reader

---
 rtl/lcd_pkg.sv | 34 +++
 rtl/lcd_bus_reader_if.sv | 27 ++
 rtl/lcd_bus_timer.sv | 43 ++++
 rtl/lcd_bus_reader.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: definitions shared by the LCD bus reader and the LCD write controller.
//   - FSM state encoding (3-bit codes; also shown on the LED debug port)
//   - default bus timing in clk cycles at 50 MHz
//   - helpers for timer load values and LED codes
package lcd_pkg;

    localparam int LCD_DATA_W = 8;
    localparam int LCD_ADDR_W = 7;
    localparam int LCD_TMR_W  = 16;

    localparam int LCD_SETUP_WAIT_DEF    = 2;
    localparam int LCD_E_HIGH_WAIT_DEF   = 12;
    localparam int LCD_RECOVERY_WAIT_DEF = 50;
    localparam int LCD_POLL_LIMIT_DEF    = 16;

    localparam logic [2:0] ST_INIT    = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_SETUP   = 3'd2;
    localparam logic [2:0] ST_E_HIGH  = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;
    localparam logic [2:0] ST_RECOVER = 3'd5;

    // The timer reports done on the last cycle of a state, so a state of N
    // cycles loads N-1. Zero or negative lengths collapse to one cycle.
    function automatic logic [LCD_TMR_W-1:0] tmr_cycles(input int cycles);
        return (cycles < 1) ? '0 : LCD_TMR_W'(cycles - 1);
    endfunction

    // INIT shows all ones so a board held in reset is obvious on the LEDs.
    function automatic logic [7:0] led_code(input logic [2:0] st);
        return (st == ST_INIT) ? 8'hff : {5'b00000, st};
    endfunction

endpackage

// File: rtl/lcd_bus_reader_if.sv
// lcd_bus_reader_if: request/response bundle of the LCD bus reader.
//   master modport: requester side (drives RD_REQ/RD_RS/RD_POLL)
//   slave  modport: lcd_bus_reader side (drives ready/valid/data/status)
interface lcd_bus_reader_if;
    import lcd_pkg::*;

    logic                  RD_REQ;
    logic                  RD_RS;
    logic                  RD_POLL;
    logic                  RD_READY;
    logic                  RD_VALID;
    logic [LCD_DATA_W-1:0] RD_DATA;
    logic                  BUSY_FLAG;
    logic [LCD_ADDR_W-1:0] ADDR;
    logic                  TIMEOUT;

    modport master (
        output RD_REQ, RD_RS, RD_POLL,
        input  RD_READY, RD_VALID, RD_DATA, BUSY_FLAG, ADDR, TIMEOUT
    );

    modport slave (
        input  RD_REQ, RD_RS, RD_POLL,
        output RD_READY, RD_VALID, RD_DATA, BUSY_FLAG, ADDR, TIMEOUT
    );

endinterface

// File: rtl/lcd_bus_timer.sv
// lcd_bus_timer: loadable 16-bit down-counter with a one-cycle done pulse.
//   clk, rst_n : clock, async active-low reset
//   load       : (re)start the count with load_val
//   load_val   : cycles to wait minus one
//   done       : high for one cycle when the count reaches zero
module lcd_bus_timer
    import lcd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [LCD_TMR_W-1:0] load_val,
    output logic                 done
);

    logic [LCD_TMR_W-1:0] cnt_q, cnt_d;
    logic                 run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load) begin
            cnt_d = load_val;
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) run_d = 1'b0;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done = run_q && (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// lcd_bus_reader: HD44780-style LCD read-cycle sequencer.
//   CLK_50MHZ, RESET_N : clock, async active-low reset
//   rd_bus             : request/response bundle (lcd_bus_reader_if.slave)
//   LCD_DB_IN          : LCD data bus, read direction
//   LCD_E/LCD_RS/LCD_RW: LCD strobe, register select, read/write
//   LED                : debug, current state code (8'hff in INIT)
// Build option: define LCD_BUSY_POLL_EN to add busy-flag polling (RD_POLL).
//
// state   | meaning
// INIT    | after reset, one cycle before accepting requests
// IDLE    | RD_READY=1, waiting for RD_REQ
// SETUP   | RS/RW settled, E low (tAS)
// E_HIGH  | E high, data sampled on the last cycle
// HOLD    | E low, RS/RW still held
// RECOVER | bus idle gap before the next access
module lcd_bus_reader
    import lcd_pkg::*;
#(
    parameter int SETUP_WAIT    = LCD_SETUP_WAIT_DEF,
    parameter int E_HIGH_WAIT   = LCD_E_HIGH_WAIT_DEF,
    parameter int RECOVERY_WAIT = LCD_RECOVERY_WAIT_DEF,
    parameter int POLL_LIMIT    = LCD_POLL_LIMIT_DEF
) (
    input  logic                    CLK_50MHZ,
    input  logic                    RESET_N,
    lcd_bus_reader_if.slave         rd_bus,
    input  logic [LCD_DATA_W-1:0]   LCD_DB_IN,
    output logic                    LCD_E,
    output logic                    LCD_RS,
    output logic                    LCD_RW,
    output logic [7:0]              LED
);

    logic [2:0]            state_q, state_d;
    logic                  rs_q, rs_d;
    logic                  valid_q, valid_d;
    logic [LCD_DATA_W-1:0] data_q, data_d;
    logic                  busy_q, busy_d;
    logic [LCD_ADDR_W-1:0] addr_q, addr_d;
    logic                  tmr_load;
    logic [LCD_TMR_W-1:0]  tmr_val;
    logic                  tmr_done;

`ifdef LCD_BUSY_POLL_EN
    logic                 poll_q, poll_d;
    logic [LCD_TMR_W-1:0] poll_cnt_q, poll_cnt_d;
    logic                 timeout_q, timeout_d;
`else
    logic                 unused_poll;
    logic [LCD_TMR_W-1:0] unused_poll_limit;
    assign unused_poll       = rd_bus.RD_POLL;
    assign unused_poll_limit = LCD_TMR_W'(POLL_LIMIT);
`endif

    lcd_bus_timer u_timer (
        .clk      (CLK_50MHZ),
        .rst_n    (RESET_N),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        rs_d     = rs_q;
        valid_d  = 1'b0;
        data_d   = data_q;
        busy_d   = busy_q;
        addr_d   = addr_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef LCD_BUSY_POLL_EN
        poll_d     = poll_q;
        poll_cnt_d = poll_cnt_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (rd_bus.RD_REQ) begin
                    state_d  = ST_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = tmr_cycles(SETUP_WAIT);
`ifdef LCD_BUSY_POLL_EN
                    // Polling only makes sense on the status register.
                    rs_d       = rd_bus.RD_POLL ? 1'b0 : rd_bus.RD_RS;
                    poll_d     = rd_bus.RD_POLL;
                    poll_cnt_d = '0;
                    timeout_d  = 1'b0;
`else
                    rs_d = rd_bus.RD_RS;
`endif
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    state_d  = ST_E_HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = tmr_cycles(E_HIGH_WAIT);
                end
            end
            ST_E_HIGH: begin
                if (tmr_done) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = tmr_cycles(1);
                    data_d   = LCD_DB_IN;
                    if (!rs_q) begin
                        busy_d = LCD_DB_IN[7];
                        addr_d = LCD_DB_IN[6:0];
                    end
`ifdef LCD_BUSY_POLL_EN
                    poll_cnt_d = poll_cnt_q + 1'b1;
`endif
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    state_d  = ST_RECOVER;
                    tmr_load = 1'b1;
                    tmr_val  = tmr_cycles(RECOVERY_WAIT);
                end
            end
            ST_RECOVER: begin
                if (tmr_done) begin
`ifdef LCD_BUSY_POLL_EN
                    // busy_q already holds the sample from this access.
                    if (poll_q && busy_q && (poll_cnt_q < LCD_TMR_W'(POLL_LIMIT))) begin
                        state_d  = ST_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = tmr_cycles(SETUP_WAIT);
                    end else begin
                        state_d   = ST_IDLE;
                        valid_d   = 1'b1;
                        timeout_d = poll_q && busy_q;
                    end
`else
                    state_d = ST_IDLE;
                    valid_d = 1'b1;
`endif
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_INIT;
            rs_q    <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b1;
            addr_q  <= '0;
`ifdef LCD_BUSY_POLL_EN
            poll_q     <= 1'b0;
            poll_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
`ifdef LCD_BUSY_POLL_EN
            poll_q     <= poll_d;
            poll_cnt_q <= poll_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    logic in_access;
    assign in_access = (state_q == ST_SETUP) || (state_q == ST_E_HIGH) || (state_q == ST_HOLD);

    assign LCD_RW = in_access;
    assign LCD_RS = in_access && rs_q;
    assign LCD_E  = (state_q == ST_E_HIGH);
    assign LED    = led_code(state_q);

    assign rd_bus.RD_READY  = (state_q == ST_IDLE);
    assign rd_bus.RD_VALID  = valid_q;
    assign rd_bus.RD_DATA   = data_q;
    assign rd_bus.BUSY_FLAG = busy_q;
    assign rd_bus.ADDR      = addr_q;
`ifdef LCD_BUSY_POLL_EN
    assign rd_bus.TIMEOUT = timeout_q;
`else
    assign rd_bus.TIMEOUT = 1'b0;
`endif

endmodule
